// File: rtl/bpt_update_ctrl.sv
// Branch-prediction-table update controller: optional init sweep (macro BPT_INIT_SWEEP_EN), then two update ports queued to one table write port.
// Latency: one cycle from acceptance to table write; both readies drop when the queue holds more than FIFO_DEPTH-2 entries.
module bpt_update_ctrl #(
    parameter int INDEX_LEN  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IN_upd0Valid,
    input  logic [INDEX_LEN-1:0] IN_upd0Addr,
    input  logic                 IN_upd0Taken,
    input  logic                 IN_upd1Valid,
    input  logic [INDEX_LEN-1:0] IN_upd1Addr,
    input  logic                 IN_upd1Taken,
    output logic                 OUT_upd0Ready,
    output logic                 OUT_upd1Ready,
    output logic                 OUT_writeEn,
    output logic [INDEX_LEN-1:0] OUT_writeAddr,
    output logic                 OUT_writeTaken,
    output logic                 OUT_writeInit,
    output logic                 OUT_initDone
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [INDEX_LEN-1:0] addr;
        logic                 taken;
    } upd_t;

    upd_t             mem_q [FIFO_DEPTH];
    upd_t             mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wp;
    logic             run, rdy, pop, acc0, acc1;

`ifdef BPT_INIT_SWEEP_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t               state_q, state_d;
    logic [INDEX_LEN-1:0] sweep_q, sweep_d;

    assign run = (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == ST_INIT) begin
            sweep_d = sweep_q + INDEX_LEN'(1);
            if (sweep_q == {INDEX_LEN{1'b1}}) begin
                state_d = ST_RUN;
            end
        end
    end
`else
    assign run = 1'b1;
`endif

    // Two free slots guarantee both ports can push even if nothing pops.
    assign rdy = !rst && run && (count_q <= CNT_W'(FIFO_DEPTH - 2));
    assign pop = run && (count_q != '0);

    assign OUT_upd0Ready = rdy;
    assign OUT_upd1Ready = rdy;
    assign OUT_initDone  = run && !rst;

    always_comb begin
        mem_d = mem_q;
        wp    = wr_ptr_q;
        acc0  = IN_upd0Valid && rdy;
        acc1  = IN_upd1Valid && rdy;
        if (acc0) begin
            mem_d[wp] = {IN_upd0Addr, IN_upd0Taken};
            wp        = wp + PTR_W'(1);
        end
        if (acc1) begin
            mem_d[wp] = {IN_upd1Addr, IN_upd1Taken};
            wp        = wp + PTR_W'(1);
        end
        wr_ptr_d = wp;
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(acc0) + CNT_W'(acc1) - CNT_W'(pop);
    end

    always_comb begin
        OUT_writeEn    = 1'b0;
        OUT_writeAddr  = '0;
        OUT_writeTaken = 1'b0;
        OUT_writeInit  = 1'b0;
`ifdef BPT_INIT_SWEEP_EN
        if (state_q == ST_INIT) begin
            OUT_writeEn   = 1'b1;
            OUT_writeInit = 1'b1;
            OUT_writeAddr = sweep_q;
        end
`endif
        // The table cannot stall, so the head is always consumed when present.
        if (pop) begin
            OUT_writeEn    = 1'b1;
            OUT_writeAddr  = mem_q[rd_ptr_q].addr;
            OUT_writeTaken = mem_q[rd_ptr_q].taken;
        end
        if (rst) begin
            OUT_writeEn    = 1'b0;
            OUT_writeAddr  = '0;
            OUT_writeTaken = 1'b0;
            OUT_writeInit  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef BPT_INIT_SWEEP_EN
            state_q  <= ST_INIT;
            sweep_q  <= '0;
`endif
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifdef BPT_INIT_SWEEP_EN
            state_q  <= state_d;
            sweep_q  <= sweep_d;
`endif
        end
    end
endmodule

// File: tb/tb_bpt_update_ctrl.sv
// Scoreboarded bench for bpt_update_ctrl: driver predicts accepted updates and their write cycle, a negedge monitor checks table writes.
`timescale 1ns/1ps
module tb_bpt_update_ctrl;
    localparam int IL    = 8;
    localparam int DEPTH = 4;
    localparam int NIDX  = 1 << IL;

    logic          clk = 1'b0;
    logic          rst;
    logic          v0, t0, v1, t1;
    logic [IL-1:0] a0, a1;
    logic          rdy0, rdy1, wr_en, wr_taken, wr_init, init_done;
    logic [IL-1:0] wr_addr;

    bpt_update_ctrl #(.INDEX_LEN(IL), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .IN_upd0Valid(v0), .IN_upd0Addr(a0), .IN_upd0Taken(t0),
        .IN_upd1Valid(v1), .IN_upd1Addr(a1), .IN_upd1Taken(t1),
        .OUT_upd0Ready(rdy0), .OUT_upd1Ready(rdy1),
        .OUT_writeEn(wr_en), .OUT_writeAddr(wr_addr), .OUT_writeTaken(wr_taken),
        .OUT_writeInit(wr_init), .OUT_initDone(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IL-1:0] addr;
        logic          taken;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   last_wr = -1;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Writes leave one per cycle in acceptance order, never earlier than the cycle after acceptance.
    task automatic push_exp(input logic [IL-1:0] a, input logic t);
        exp_t e;
        e.addr  = a;
        e.taken = t;
        e.cyc   = (cyc + 1 > last_wr + 1) ? cyc + 1 : last_wr + 1;
        last_wr = e.cyc;
        exp_q.push_back(e);
    endtask

    task automatic drive_cycle(input logic pv0, input logic [IL-1:0] pa0, input logic pt0,
                               input logic pv1, input logic [IL-1:0] pa1, input logic pt1);
        logic rdy_exp;
        @(posedge clk);
        #1;
        rdy_exp = (exp_q.size() <= DEPTH - 2);
        chk("upd0_ready", 32'(rdy0), 32'(rdy_exp));
        chk("upd1_ready", 32'(rdy1), 32'(rdy_exp));
        v0 = pv0; a0 = pa0; t0 = pt0;
        v1 = pv1; a1 = pa1; t1 = pt1;
        if (pv0 && rdy_exp) push_exp(pa0, pt0);
        if (pv1 && rdy_exp) push_exp(pa1, pt1);
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic rand_cycle(input int pct);
        logic          rv0, rv1, rt0, rt1;
        logic [IL-1:0] ra0, ra1;
        rv0 = ($urandom_range(0, 99) < pct);
        rv1 = ($urandom_range(0, 99) < pct);
        rt0 = 1'($urandom_range(0, 1));
        rt1 = 1'($urandom_range(0, 1));
        ra0 = IL'($urandom);
        ra1 = IL'($urandom);
        drive_cycle(rv0, ra0, rt0, rv1, ra1, rt1);
    endtask

    // Releases reset; with the sweep enabled, checks it and optionally re-asserts reset at abort_at.
    task automatic release_and_init(input int abort_at);
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef BPT_INIT_SWEEP_EN
        v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < NIDX; i++) begin
            @(negedge clk);
            chk("sweep_en", 32'(wr_en), 32'd1);
            chk("sweep_init", 32'(wr_init), 32'd1);
            chk("sweep_addr", 32'(wr_addr), 32'(i));
            chk("sweep_rdy0", 32'(rdy0), 32'd0);
            chk("sweep_rdy1", 32'(rdy1), 32'd0);
            chk("sweep_done", 32'(init_done), 32'd0);
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_en", 32'(wr_en), 32'd0);
                chk("abort_init", 32'(wr_init), 32'd0);
                v0 = 1'b0; v1 = 1'b0;
                return;
            end
        end
        v0 = 1'b0; v1 = 1'b0;
`else
        #1;
        chk("first_done", 32'(init_done), 32'd1);
        chk("first_rdy0", 32'(rdy0), 32'd1);
        chk("first_rdy1", 32'(rdy1), 32'd1);
        chk("first_en", 32'(wr_en), 32'd0);
`endif
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                chk("wr_en", 32'(wr_en), 32'd1);
                chk("wr_addr", 32'(wr_addr), 32'(exp_q[0].addr));
                chk("wr_taken", 32'(wr_taken), 32'(exp_q[0].taken));
                void'(exp_q.pop_front());
            end else begin
                chk("idle_en", 32'(wr_en), 32'd0);
                chk("idle_addr", 32'(wr_addr), 32'd0);
                chk("idle_taken", 32'(wr_taken), 32'd0);
            end
            chk("run_init", 32'(wr_init), 32'd0);
            chk("run_done", 32'(init_done), 32'd1);
        end
    end

    initial begin
        int pcts[3];
        pcts = '{25, 60, 100};
        rst = 1'b1;
        v0 = 1'b0; a0 = '0; t0 = 1'b0;
        v1 = 1'b0; a1 = '0; t1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", 32'(wr_en), 32'd0);
        chk("rst_init", 32'(wr_init), 32'd0);
        chk("rst_rdy0", 32'(rdy0), 32'd0);
        chk("rst_rdy1", 32'(rdy1), 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
`ifdef BPT_INIT_SWEEP_EN
        release_and_init(100);
`endif
        release_and_init(-1);
        mon_en = 1'b1;

        drive_cycle(1'b1, 8'h3A, 1'b1, 1'b0, '0, 1'b0);
        repeat (3) idle_cycle();

        drive_cycle(1'b1, 8'h10, 1'b1, 1'b1, 8'h20, 1'b0);
        drive_cycle(1'b1, 8'h11, 1'b1, 1'b1, 8'h21, 1'b0);
        repeat (5) idle_cycle();

        repeat (6) rand_cycle(100);
        repeat (8) idle_cycle();
        chk("drained_bp", 32'(exp_q.size()), 32'd0);

        foreach (pcts[k]) begin
            repeat (600) rand_cycle(pcts[k]);
        end
        repeat (8) idle_cycle();
        chk("drained_rand", 32'(exp_q.size()), 32'd0);

        repeat (4) rand_cycle(100);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0;
        exp_q.delete();
        last_wr = -1;
        #1;
        chk("mid_rst_en", 32'(wr_en), 32'd0);
        chk("mid_rst_rdy0", 32'(rdy0), 32'd0);
        chk("mid_rst_done", 32'(init_done), 32'd0);
        release_and_init(-1);
        mon_en = 1'b1;
        repeat (300) rand_cycle(50);
        repeat (8) idle_cycle();
        chk("drained_final", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/bpt_update_ctrl.md
BPT_UPDATE_CTRL -- requirements
Module: bpt_update_ctrl

Interface
REQ-001 The block SHALL have parameter INDEX_LEN, default 8, giving the table index width (2^INDEX_LEN counters).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the update-queue depth; it SHALL be a power of two and at least 2.
REQ-003 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 IN_upd0Valid / IN_upd1Valid  input  1 each  resolved-branch update request from branch unit 0 / 1.
REQ-006 IN_upd0Addr / IN_upd1Addr  input  INDEX_LEN each  counter index of the update.
REQ-007 IN_upd0Taken / IN_upd1Taken  input  1 each  resolved direction of the branch.
REQ-008 OUT_upd0Ready / OUT_upd1Ready  output  1 each  the update is accepted this cycle when valid and ready are both 1.
REQ-009 OUT_writeEn  output  1  write strobe to the prediction table.
REQ-010 OUT_writeAddr  output  INDEX_LEN  table index to write.
REQ-011 OUT_writeTaken  output  1  saturating increment (1) or decrement (0).
REQ-012 OUT_writeInit  output  1  force the counter to 2'b10; OUT_writeTaken is ignored when set.
REQ-013 OUT_initDone  output  1  table initialisation is complete.

Function
REQ-014 The FSM SHALL have two states: INIT (table initialisation sweep) and RUN.
REQ-015 In INIT, each cycle SHALL drive OUT_writeEn=1, OUT_writeInit=1 and OUT_writeAddr=sweep counter; the counter starts at 0 and increments by 1 per cycle.
REQ-016 When the sweep counter equals 2^INDEX_LEN-1, the next edge SHALL enter RUN. The sweep takes exactly 2^INDEX_LEN cycles, with no wrap and no repeated index.
REQ-017 In INIT, both readies SHALL be 0 and OUT_initDone SHALL be 0; in RUN, OUT_initDone SHALL be 1.
REQ-018 In RUN, both readies SHALL be 1 if the registered FIFO occupancy is at most FIFO_DEPTH-2, and both SHALL be 0 otherwise; readies SHALL NOT depend on any input.
REQ-019 Accepted updates SHALL be pushed into the FIFO, at most two per cycle; when both are accepted, upd0 SHALL be enqueued ahead of upd1.
REQ-020 In RUN with the FIFO non-empty, the head entry SHALL drive OUT_writeEn=1, OUT_writeAddr and OUT_writeTaken, with OUT_writeInit=0, and SHALL be popped at that edge, because the table has no backpressure.
REQ-021 In RUN with the FIFO empty, OUT_writeEn SHALL be 0 and the other write outputs SHALL be 0.
REQ-022 Latency SHALL be one cycle: an update accepted at edge N into an empty FIFO SHALL be written in the cycle following edge N.
REQ-023 Push and pop in the same cycle SHALL be legal; occupancy SHALL become old + pushes - pops and SHALL never exceed FIFO_DEPTH.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH with no loss or duplication of entries.
REQ-025 Updates to the same index SHALL be written in acceptance order and never merged.

Reset
REQ-026 Asserting rst SHALL immediately clear the FIFO (occupancy 0, pointers 0) and the sweep counter, and SHALL enter INIT; without BPT_INIT_SWEEP_EN it SHALL enter RUN instead.
REQ-027 While rst is high, OUT_writeEn, OUT_writeInit, both readies and OUT_initDone SHALL be 0.
REQ-028 Reset asserted mid-sweep or mid-drain SHALL discard all progress; the sweep SHALL restart at index 0 after release.

Configuration
REQ-029 Macro BPT_INIT_SWEEP_EN SHALL select the initialisation sweep.
REQ-030 With BPT_INIT_SWEEP_EN defined, the block SHALL perform INIT as specified above.
REQ-031 Without BPT_INIT_SWEEP_EN, the block SHALL have no INIT state or sweep counter: OUT_writeInit is tied to 0, and OUT_initDone is 1 in the first cycle after rst deasserts.

Verification
REQ-032 Sweep: with the macro on and INDEX_LEN=8, release rst -> exactly 256 init writes, addresses 0..255; OUT_initDone rises in cycle 257; readies are 0 throughout the sweep.
REQ-033 Single update: in RUN, upd0 valid with addr 0x3A, taken=1, FIFO empty -> next cycle OUT_writeEn=1, addr 0x3A, taken 1, OUT_writeInit 0; the following cycle OUT_writeEn=0.
REQ-034 Ordering: both valid every cycle with (0x10,1) / (0x20,0), then (0x11,1) / (0x21,0) -> writes appear in the order 0x10, 0x20, 0x11, 0x21.
REQ-035 Backpressure: FIFO_DEPTH=4, both valid continuously for 6 cycles -> readies drop whenever occupancy is 3 or more; every accepted update is written exactly once and no unaccepted update is written.
REQ-036 Reset mid-sweep: assert rst at sweep index 100 -> OUT_writeEn drops immediately; after release, the sweep restarts at 0 and again lasts 256 cycles.
REQ-037 Macro off: release rst -> OUT_initDone=1 and readies=1 in the first cycle; OUT_writeInit is never 1.
